// File: rtl/ret_stack.sv
// Return-address stack (LIFO) for call/return flow. Pops feed the program
// counter through a registered address and a one-cycle load strobe.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_addr,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] L_DEPTH = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] L_ONE   = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_pc_in;
  logic             r_pc_load;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  // When full the low PTR_W bits of count are zero, so count-1 wraps to the
  // last slot, which is exactly the top entry.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_DEPTH);
  assign w_top_idx = r_count[PTR_W-1:0] - PTR_W'(1);

  // A push alongside an accepted pop replaces the top; otherwise it needs room.
  assign w_pop_ok  = pop & ~w_empty;
  assign w_push_ok = push & ~w_pop_ok & ~w_full;
  assign w_wr_en   = ~reset & push & (w_pop_ok | ~w_full);
  assign w_wr_idx  = w_pop_ok ? w_top_idx : r_count[PTR_W-1:0];

  // NOTE: storage has no reset; entries above count are never observed, so
  // clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_pc_in     <= '0;
      r_pc_load   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc_load <= w_pop_ok;
      if (w_pop_ok) begin
        r_pc_in <= r_mem[w_top_idx];
      end
      if (w_pop_ok && !push) begin
        r_count <= r_count - L_ONE;
      end else if (w_push_ok) begin
        r_count <= r_count + L_ONE;
      end
      if (push && w_full && !w_pop_ok) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign top       = w_empty ? '0 : r_mem[w_top_idx];
  assign pc_in     = r_pc_in;
  assign pc_load   = r_pc_load;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack with a small program-counter model attached
// to pc_in/pc_load.
module tb_ret_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] push_addr;
  logic [15:0] top;
  logic [15:0] pc_in;
  logic        pc_load;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] pc_model;
  logic        pc_saw_55;

  ret_stack #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top       (top),
    .pc_in     (pc_in),
    .pc_load   (pc_load),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Program counter fed by the stack; shares the stack's reset.
  always @(posedge clk) begin
    if (reset) begin
      pc_model  <= 16'h0000;
      pc_saw_55 <= 1'b0;
    end else if (pc_load) begin
      pc_model <= pc_in;
      if (pc_in == 16'h0055) pc_saw_55 <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic [15:0] a);
    push = p;
    pop = q;
    push_addr = a;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    push_addr = 16'h0000;
    cyc(0, 0, 16'h0);
    cyc(0, 0, 16'h0);
    reset = 1'b0;
    repeat (3) cyc(0, 0, 16'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_top", 32'(top), 32'h0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_pc_in", 32'(pc_in), 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    // Three pushes, then three back-to-back pops.
    cyc(1, 0, 16'h0010);
    check("p1_count", 32'(count), 32'd1);
    check("p1_top", 32'(top), 32'h0010);
    cyc(1, 0, 16'h0020);
    cyc(1, 0, 16'h0030);
    check("p3_count", 32'(count), 32'd3);
    check("p3_top", 32'(top), 32'h0030);
    cyc(0, 1, 16'h0);
    check("pop1_pc_in", 32'(pc_in), 32'h0030);
    check("pop1_load", 32'(pc_load), 32'd1);
    check("pop1_count", 32'(count), 32'd2);
    cyc(0, 1, 16'h0);
    check("pop2_pc_in", 32'(pc_in), 32'h0020);
    check("pop2_load", 32'(pc_load), 32'd1);
    check("pop2_count", 32'(count), 32'd1);
    cyc(0, 1, 16'h0);
    check("pop3_pc_in", 32'(pc_in), 32'h0010);
    check("pop3_load", 32'(pc_load), 32'd1);
    check("pop3_count", 32'(count), 32'd0);
    check("pop3_empty", 32'(empty), 32'd1);
    cyc(0, 0, 16'h0);
    check("idle_load", 32'(pc_load), 32'd0);
    check("idle_pc_in_hold", 32'(pc_in), 32'h0010);
    check("pc_after_pops", 32'(pc_model), 32'h0010);

    // Fill to capacity, then one rejected push.
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'h0100 + 16'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_top", 32'(top), 32'h0107);
    check("fill_ovf_clear", 32'(overflow), 32'd0);
    cyc(1, 0, 16'h0AAA);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_top", 32'(top), 32'h0107);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 16'h0);
      check("drain_pc_in", 32'(pc_in), 32'h0107 - 32'(i));
      check("drain_load", 32'(pc_load), 32'd1);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Pop from empty, then a push still works.
    cyc(0, 1, 16'h0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_load", 32'(pc_load), 32'd0);
    check("unf_count", 32'(count), 32'd0);
    check("unf_pc_in_hold", 32'(pc_in), 32'h0100);
    cyc(1, 0, 16'h0042);
    check("unf_push_top", 32'(top), 32'h0042);
    check("unf_push_count", 32'(count), 32'd1);
    check("unf_sticky", 32'(underflow), 32'd1);

    // Push+pop on empty: pop rejected, push proceeds.
    reset = 1'b1;
    cyc(0, 0, 16'h0);
    reset = 1'b0;
    check("rst2_unf", 32'(underflow), 32'd0);
    check("rst2_ovf", 32'(overflow), 32'd0);
    cyc(1, 1, 16'h0077);
    check("pp_empty_unf", 32'(underflow), 32'd1);
    check("pp_empty_load", 32'(pc_load), 32'd0);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_top", 32'(top), 32'h0077);

    // Tail-call replace on [0011, 0022].
    reset = 1'b1;
    cyc(0, 0, 16'h0);
    reset = 1'b0;
    cyc(1, 0, 16'h0011);
    cyc(1, 0, 16'h0022);
    cyc(1, 1, 16'h0033);
    check("rep_pc_in", 32'(pc_in), 32'h0022);
    check("rep_load", 32'(pc_load), 32'd1);
    check("rep_count", 32'(count), 32'd2);
    check("rep_top", 32'(top), 32'h0033);
    for (int i = 0; i < 6; i++) cyc(1, 0, 16'h0200 + 16'(i));
    check("rep_fill_full", 32'(full), 32'd1);
    cyc(1, 1, 16'h0044);
    check("rep_full_pc_in", 32'(pc_in), 32'h0205);
    check("rep_full_load", 32'(pc_load), 32'd1);
    check("rep_full_count", 32'(count), 32'd8);
    check("rep_full_top", 32'(top), 32'h0044);
    check("rep_full_no_ovf", 32'(overflow), 32'd0);
    cyc(0, 1, 16'h0);
    check("rep_below_pc_in", 32'(pc_in), 32'h0044);
    check("rep_below_top", 32'(top), 32'h0204);
    cyc(1, 0, 16'h0066);
    cyc(1, 0, 16'h0088);
    check("rep_ovf_set", 32'(overflow), 32'd1);

    // Reset lands while pc_load is high; the PC must never see 0055.
    cyc(0, 1, 16'h0);
    check("pre55_count", 32'(count), 32'd7);
    cyc(1, 0, 16'h0055);
    cyc(0, 1, 16'h0);
    check("pop55_pc_in", 32'(pc_in), 32'h0055);
    check("pop55_load", 32'(pc_load), 32'd1);
    reset = 1'b1;
    cyc(0, 0, 16'h0);
    reset = 1'b0;
    check("rst55_load", 32'(pc_load), 32'd0);
    check("rst55_pc_in", 32'(pc_in), 32'h0);
    check("rst55_count", 32'(count), 32'd0);
    check("rst55_ovf", 32'(overflow), 32'd0);
    check("rst55_unf", 32'(underflow), 32'd0);
    repeat (3) cyc(0, 0, 16'h0);
    check("pc_never_55", 32'(pc_saw_55), 32'd0);
    check("pc_model_zero", 32'(pc_model), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
